// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle produced by vga_timing_gen and consumed by renderers.
//   o_pix_ce  one-cycle pixel strobe; sample the fields below when it is high
//   o_hsync   horizontal sync at the configured polarity
//   o_vsync   vertical sync at the configured polarity
//   o_active  high inside the visible region
//   o_x, o_y  raw raster position (not zeroed in blanking)
//   o_sol     start-of-line strobe (x == 0)
//   o_sof     start-of-frame strobe (x == 0, y == 0)
//   o_frame   frame counter, wraps modulo 2^FRAME_W
// Modports: master = timing generator, slave = pixel consumer.
// ----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int FRAME_W = 12
);
    logic               o_pix_ce;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_active;
    logic [11:0]        o_x;
    logic [11:0]        o_y;
    logic               o_sol;
    logic               o_sof;
    logic [FRAME_W-1:0] o_frame;

    modport master (
        output o_pix_ce, o_hsync, o_vsync, o_active,
               o_x, o_y, o_sol, o_sof, o_frame
    );

    modport slave (
        input  o_pix_ce, o_hsync, o_vsync, o_active,
               o_x, o_y, o_sol, o_sof, o_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator running from a single system clock.
// A pixel-clock-enable divider produces one pixel step every CLK_DIV enabled
// cycles; at each step the raster position advances and every output is
// re-registered from the new position.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset (wins over i_en)
//   i_en   run enable; low freezes divider, position and frame counter
//   vga    timing outputs (vga_timing_gen_if.master)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   FRAME_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || CLK_DIV < 1) begin : g_bad_cfg
            $error("vga_timing_gen: invalid raster/divider configuration");
        end
    endgenerate

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0]      H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]      V_LAST   = 12'(V_TOTAL - 1);

    // 13-bit bounds so a sync window ending exactly at 4096 still compares
    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

    // ST_LOAD: the next pixel step loads (0,0) instead of advancing
    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e             state_q,  state_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [11:0]        h_q,      h_d;
    logic [11:0]        v_q,      v_d;
    logic [FRAME_W-1:0] frame_q,  frame_d;
    logic               pix_ce_q, pix_ce_d;
    logic               sol_q,    sol_d;
    logic               sof_q,    sof_d;
    logic               hsync_q,  hsync_d;
    logic               vsync_q,  vsync_d;
    logic               active_q, active_d;
    logic               step;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        frame_d  = frame_q;
        pix_ce_d = 1'b0;
        sol_d    = 1'b0;
        sof_d    = 1'b0;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        active_d = active_q;

        step = i_en && (div_q == DIV_LAST);

        if (i_en) begin
            div_d = step ? '0 : div_q + 1'b1;
        end

        if (step) begin
            if (state_q == ST_LOAD) begin
                h_d     = '0;
                v_d     = '0;
                state_d = ST_RUN;
            end else if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = frame_q + 1'b1;
                end else begin
                    v_d = v_q + 12'd1;
                end
            end else begin
                h_d = h_q + 12'd1;
            end

            // Every output is derived from the position being loaded now
            pix_ce_d = 1'b1;
            sol_d    = (h_d == '0);
            sof_d    = (h_d == '0) && (v_d == '0);
            active_d = ({1'b0, h_d} < H_ACT_END) && ({1'b0, v_d} < V_ACT_END);
            hsync_d  = (({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END))
                       ? HS_POL : ~HS_POL;
            vsync_d  = (({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END))
                       ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_LOAD;
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= '0;
            pix_ce_q <= 1'b0;
            sol_q    <= 1'b0;
            sof_q    <= 1'b0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
            pix_ce_q <= pix_ce_d;
            sol_q    <= sol_d;
            sof_q    <= sof_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
        end
    end

    assign vga.o_pix_ce = pix_ce_q;
    assign vga.o_hsync  = hsync_q;
    assign vga.o_vsync  = vsync_q;
    assign vga.o_active = active_q;
    assign vga.o_x      = h_q;
    assign vga.o_y      = v_q;
    assign vga.o_sol    = sol_q;
    assign vga.o_sof    = sof_q;
    assign vga.o_frame  = frame_q;

endmodule
